// File: rtl/wb_sdram_pkg.sv
// Shared types for the multi-port Wishbone front-end of the SDRAM controller.
package wb_sdram_pkg;

  localparam int PKG_NUM_PORTS  = 4;
  localparam int PKG_ADDR_BITS  = 23;
  localparam int PKG_DATA_BYTES = 2;
  localparam int PKG_MAX_RD     = 8;

  // Width of a port-ID tag; a single-port build still needs one bit.
  function automatic int portBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PKG_PORT_BITS = portBits(PKG_NUM_PORTS);

  typedef logic [PKG_PORT_BITS-1:0] port_id_t;

  // One command word as handed to the SDRAM controller.
  typedef struct packed {
    logic [PKG_ADDR_BITS-1:0]    addr;
    logic                        we;
    logic [PKG_DATA_BYTES*8-1:0] dat;
    logic [PKG_DATA_BYTES-1:0]   sel;
  } sdram_cmd_t;

endpackage

// File: rtl/wb_sdram_mport_if.sv
// Bundle of the per-port Wishbone slave signals, the command stream and the
// read-response stream of the SDRAM front-end.
interface wb_sdram_mport_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_BITS  = 23,
  parameter int DATA_BYTES = 2
);
  logic [NUM_PORTS*ADDR_BITS-1:0]    s_wb_addr;
  logic [NUM_PORTS*DATA_BYTES*8-1:0] s_wb_dat_m2s;
  logic [NUM_PORTS*DATA_BYTES-1:0]   s_wb_sel;
  logic [NUM_PORTS-1:0]              s_wb_we;
  logic [NUM_PORTS-1:0]              s_wb_stb;
  logic [NUM_PORTS-1:0]              s_wb_stall;
  logic [NUM_PORTS-1:0]              s_wb_ack;
  logic [DATA_BYTES*8-1:0]           s_wb_dat_s2m;
  logic                              cmd_o_valid;
  logic                              cmd_o_ready;
  logic [ADDR_BITS-1:0]              cmd_o_addr;
  logic                              cmd_o_we;
  logic [DATA_BYTES*8-1:0]           cmd_o_dat;
  logic [DATA_BYTES-1:0]             cmd_o_sel;
  logic                              rsp_i_valid;
  logic [DATA_BYTES*8-1:0]           rsp_i_dat;
  logic                              err;

  modport slave (
    input  s_wb_addr, s_wb_dat_m2s, s_wb_sel, s_wb_we, s_wb_stb,
    output s_wb_stall, s_wb_ack, s_wb_dat_s2m,
    output cmd_o_valid, cmd_o_addr, cmd_o_we, cmd_o_dat, cmd_o_sel,
    input  cmd_o_ready,
    input  rsp_i_valid, rsp_i_dat,
    output err
  );

  modport master (
    output s_wb_addr, s_wb_dat_m2s, s_wb_sel, s_wb_we, s_wb_stb,
    input  s_wb_stall, s_wb_ack, s_wb_dat_s2m,
    input  cmd_o_valid, cmd_o_addr, cmd_o_we, cmd_o_dat, cmd_o_sel,
    output cmd_o_ready,
    output rsp_i_valid, rsp_i_dat,
    input  err
  );
endinterface

// File: rtl/wb_sdram_mport_fifo.sv
// Small AXI-stream style FIFO carrying only tuser. A pop frees its slot for a
// push in the same cycle, so a full FIFO still accepts while draining.
module axis_fifo #(
  parameter int DEPTH      = 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [USER_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_wrPtr;
  logic [PTR_BITS-1:0]   r_rdPtr;
  logic [CNT_BITS-1:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign m_axis_tvalid = (r_count != '0);
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = (r_count != CNT_BITS'(DEPTH)) || w_pop;
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tuser  = r_mem[r_rdPtr];

  // Storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= s_axis_tuser;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= (int'(r_wrPtr) == DEPTH - 1) ? '0 : r_wrPtr + PTR_BITS'(1);
      if (w_pop)  r_rdPtr <= (int'(r_rdPtr) == DEPTH - 1) ? '0 : r_rdPtr + PTR_BITS'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_sdram_mport_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, and the
// pointer moves just past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                clk,
  input  logic                sresetn,
  input  logic [N-1:0]        i_req,
  input  logic                i_advance,
  output logic [N-1:0]        o_grant,
  output logic [IDX_BITS-1:0] o_grantIdx,
  output logic                o_anyReq
);

  logic [IDX_BITS-1:0] r_rrPtr;
  int                  w_scan;

  // Scan the request vector starting at the pointer, wrapping once.
  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    o_anyReq   = 1'b0;
    w_scan     = 0;
    for (int i = 0; i < N; i++) begin
      w_scan = int'(r_rrPtr) + i;
      if (w_scan >= N) w_scan = w_scan - N;
      if (!o_anyReq && i_req[w_scan]) begin
        o_anyReq        = 1'b1;
        o_grantIdx      = IDX_BITS'(w_scan);
        o_grant[w_scan] = 1'b1;
      end
    end
  end

  // Advance the pointer past the port that was just served.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn)
      r_rrPtr <= '0;
    else if (i_advance)
      r_rrPtr <= (int'(o_grantIdx) == N - 1) ? '0 : o_grantIdx + IDX_BITS'(1);
  end

endmodule

// File: rtl/wb_sdram_mport.sv
// Multi-port pipelined Wishbone front-end: round-robin merges the ports onto
// one SDRAM command stream and steers in-order read data back via a tag FIFO.
module wb_sdram_mport
  import wb_sdram_pkg::*;
#(
  parameter int NUM_PORTS          = PKG_NUM_PORTS,
  parameter int ADDR_BITS          = PKG_ADDR_BITS,
  parameter int DATA_BYTES         = PKG_DATA_BYTES,
  parameter int MAX_RD_OUTSTANDING = PKG_MAX_RD
) (
  input logic              clk,
  input logic              sresetn,
  wb_sdram_mport_if.slave  bus
);

  localparam int PORT_BITS = portBits(NUM_PORTS);
  localparam int DW        = DATA_BYTES * 8;
  localparam int CNT_BITS  = $clog2(MAX_RD_OUTSTANDING + 1);

  logic [CNT_BITS-1:0]  r_rdCnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_ack;
  logic [DW-1:0]        r_rdDat;
  logic                 r_err;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_grantOh;
  logic [PORT_BITS-1:0] w_grantIdx;
  logic                 w_anyReq;
  logic                 w_accept;
  logic                 w_tagReady;
  logic                 w_tagValid;
  logic [PORT_BITS-1:0] w_tagHead;
  logic                 w_pop;
  sdram_cmd_t           w_cmd;

  // A write waits for its own port's reads to drain; a read needs a tag slot.
  always_comb begin
    w_req = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      w_req[p] = bus.s_wb_stb[p] &&
                 (bus.s_wb_we[p] ? (r_rdCnt[p] == '0) : w_tagReady);
  end

  rr_arbiter #(.N(NUM_PORTS), .IDX_BITS(PORT_BITS)) u_arb (
    .clk        (clk),
    .sresetn    (sresetn),
    .i_req      (w_req),
    .i_advance  (w_accept),
    .o_grant    (w_grantOh),
    .o_grantIdx (w_grantIdx),
    .o_anyReq   (w_anyReq)
  );

  // Steer the granted port's request fields onto the command stream.
  always_comb begin
    w_cmd      = '0;
    w_cmd.addr = bus.s_wb_addr[int'(w_grantIdx)*ADDR_BITS +: ADDR_BITS];
    w_cmd.we   = bus.s_wb_we[w_grantIdx];
    w_cmd.dat  = bus.s_wb_dat_m2s[int'(w_grantIdx)*DW +: DW];
    w_cmd.sel  = bus.s_wb_sel[int'(w_grantIdx)*DATA_BYTES +: DATA_BYTES];
  end

  assign w_accept         = w_anyReq && bus.cmd_o_ready;
  assign w_pop            = bus.rsp_i_valid && w_tagValid;

  assign bus.cmd_o_valid  = w_anyReq;
  assign bus.cmd_o_addr   = w_cmd.addr;
  assign bus.cmd_o_we     = w_cmd.we;
  assign bus.cmd_o_dat    = w_cmd.dat;
  assign bus.cmd_o_sel    = w_cmd.sel;
  assign bus.s_wb_stall   = ~(w_grantOh & {NUM_PORTS{w_accept}});
  assign bus.s_wb_ack     = r_ack;
  assign bus.s_wb_dat_s2m = r_rdDat;
  assign bus.err          = r_err;

  axis_fifo #(.DEPTH(MAX_RD_OUTSTANDING), .USER_WIDTH(PORT_BITS)) u_tagFifo (
    .clk           (clk),
    .sresetn       (sresetn),
    .s_axis_tvalid (w_accept && !w_cmd.we),
    .s_axis_tready (w_tagReady),
    .s_axis_tuser  (w_grantIdx),
    .m_axis_tvalid (w_tagValid),
    .m_axis_tready (bus.rsp_i_valid),
    .m_axis_tuser  (w_tagHead)
  );

  // Per-port count of reads in flight; issue and return may cancel out.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      for (int p = 0; p < NUM_PORTS; p++) r_rdCnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case ({w_accept && !w_cmd.we && (int'(w_grantIdx) == p),
               w_pop && (int'(w_tagHead) == p)})
          2'b10:   r_rdCnt[p] <= r_rdCnt[p] + CNT_BITS'(1);
          2'b01:   r_rdCnt[p] <= r_rdCnt[p] - CNT_BITS'(1);
          default: r_rdCnt[p] <= r_rdCnt[p];
        endcase
      end
    end
  end

  // One-cycle acks: write ack to the granted port, read ack to the head tag.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_ack   <= '0;
      r_rdDat <= '0;
    end else begin
      r_ack <= '0;
      if (w_accept && w_cmd.we) r_ack[w_grantIdx] <= 1'b1;
      if (w_pop) begin
        r_ack[w_tagHead] <= 1'b1;
        r_rdDat          <= bus.rsp_i_dat;
      end
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn)
      r_err <= 1'b0;
    else if (bus.rsp_i_valid && !w_tagValid)
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_sdram_mport.sv
// Directed bench for wb_sdram_mport: write path, round-robin, read routing,
// write-after-read ordering, tag-FIFO full, dropped response and reset.
module tb_wb_sdram_mport;

  localparam int NP   = 4;
  localparam int AB   = 23;
  localparam int DB   = 2;
  localparam int MAXR = 8;

  logic clk = 1'b0;
  logic sresetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [NP-1:0] expMask;

  wb_sdram_mport_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BYTES(DB)) bus ();

  wb_sdram_mport #(
    .NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BYTES(DB), .MAX_RD_OUTSTANDING(MAXR)
  ) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic [AB-1:0] addr,
                               input logic [15:0] dat, input logic [1:0] sel,
                               input logic we, input logic stb);
    bus.s_wb_addr[p*AB +: AB]     = addr;
    bus.s_wb_dat_m2s[p*16 +: 16]  = dat;
    bus.s_wb_sel[p*DB +: DB]      = sel;
    bus.s_wb_we[p]                = we;
    bus.s_wb_stb[p]               = stb;
  endtask

  task automatic clearInputs();
    bus.s_wb_addr    = '0;
    bus.s_wb_dat_m2s = '0;
    bus.s_wb_sel     = '0;
    bus.s_wb_we      = '0;
    bus.s_wb_stb     = '0;
    bus.cmd_o_ready  = 1'b1;
    bus.rsp_i_valid  = 1'b0;
    bus.rsp_i_dat    = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    sresetn = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 sresetn = 1'b1;
  endtask

  initial begin
    // Reset state
    clearInputs();
    midCycle();
    checkOutput("rst_ack", bus.s_wb_ack, 0);
    checkOutput("rst_dat", bus.s_wb_dat_s2m, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_valid", bus.cmd_o_valid, 0);
    checkOutput("rst_stall", bus.s_wb_stall, 4'hF);
    @(posedge clk);
    #1 sresetn = 1'b1;

    // Single write from port 0
    applyStimulus(0, 23'h000123, 16'hBEEF, 2'b11, 1'b1, 1'b1);
    midCycle();
    checkOutput("wr_valid", bus.cmd_o_valid, 1);
    checkOutput("wr_addr", bus.cmd_o_addr, 23'h000123);
    checkOutput("wr_dat", bus.cmd_o_dat, 16'hBEEF);
    checkOutput("wr_sel", bus.cmd_o_sel, 2'b11);
    checkOutput("wr_we", bus.cmd_o_we, 1);
    checkOutput("wr_stall", bus.s_wb_stall, 4'b1110);
    nextCycle();
    applyStimulus(0, 23'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    midCycle();
    checkOutput("wr_ack", bus.s_wb_ack, 4'b0001);
    nextCycle();
    midCycle();
    checkOutput("wr_ack_clr", bus.s_wb_ack, 0);

    // Round-robin over four continuously writing ports
    doReset();
    for (int p = 0; p < NP; p++)
      applyStimulus(p, AB'(32'h100 + p), 16'(32'h1000 + p), 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      midCycle();
      expMask = ~(NP'(1) << (k % 4));
      checkOutput("rr_stall", bus.s_wb_stall, expMask);
      checkOutput("rr_addr", bus.cmd_o_addr, 32'h100 + (k % 4));
      expMask = (k == 0) ? '0 : (NP'(1) << ((k - 1) % 4));
      checkOutput("rr_ack", bus.s_wb_ack, expMask);
      nextCycle();
    end
    bus.cmd_o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      midCycle();
      checkOutput("hold_stall", bus.s_wb_stall, 4'hF);
      checkOutput("hold_addr", bus.cmd_o_addr, 23'h101);
      checkOutput("hold_ack", bus.s_wb_ack, (k == 0) ? 4'b0001 : 4'b0000);
      nextCycle();
    end
    bus.cmd_o_ready = 1'b1;
    midCycle();
    checkOutput("hold_release", bus.s_wb_stall, 4'b1101);
    nextCycle();

    // Read routing: port 2 then port 1, responses return in issue order
    doReset();
    applyStimulus(2, 23'h10, 16'h0, 2'b11, 1'b0, 1'b1);
    midCycle();
    checkOutput("rd2_stall", bus.s_wb_stall, 4'b1011);
    checkOutput("rd2_we", bus.cmd_o_we, 0);
    nextCycle();
    applyStimulus(2, 23'h10, 16'h0, 2'b11, 1'b0, 1'b0);
    applyStimulus(1, 23'h20, 16'h0, 2'b11, 1'b0, 1'b1);
    midCycle();
    checkOutput("rd1_stall", bus.s_wb_stall, 4'b1101);
    checkOutput("rd1_addr", bus.cmd_o_addr, 23'h20);
    nextCycle();
    applyStimulus(1, 23'h20, 16'h0, 2'b11, 1'b0, 1'b0);
    bus.rsp_i_valid = 1'b1;
    bus.rsp_i_dat   = 16'hAAAA;
    midCycle();
    checkOutput("rd_noack", bus.s_wb_ack, 0);
    nextCycle();
    bus.rsp_i_dat = 16'h5555;
    midCycle();
    checkOutput("rsp2_ack", bus.s_wb_ack, 4'b0100);
    checkOutput("rsp2_dat", bus.s_wb_dat_s2m, 16'hAAAA);
    nextCycle();
    bus.rsp_i_valid = 1'b0;
    midCycle();
    checkOutput("rsp1_ack", bus.s_wb_ack, 4'b0010);
    checkOutput("rsp1_dat", bus.s_wb_dat_s2m, 16'h5555);
    nextCycle();
    midCycle();
    checkOutput("rsp_done_ack", bus.s_wb_ack, 0);
    checkOutput("rsp_done_err", bus.err, 0);

    // Ordering guard: port 3 write waits behind its own read
    doReset();
    applyStimulus(3, 23'h30, 16'h0, 2'b11, 1'b0, 1'b1);
    midCycle();
    checkOutput("ord_rd_stall", bus.s_wb_stall, 4'b0111);
    nextCycle();
    applyStimulus(3, 23'h31, 16'h1234, 2'b01, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      midCycle();
      checkOutput("ord_wr_blocked", bus.cmd_o_valid, 0);
      checkOutput("ord_wr_stall", bus.s_wb_stall, 4'hF);
      nextCycle();
    end
    bus.rsp_i_valid = 1'b1;
    bus.rsp_i_dat   = 16'hCAFE;
    midCycle();
    checkOutput("ord_pop_blocked", bus.cmd_o_valid, 0);
    nextCycle();
    bus.rsp_i_valid = 1'b0;
    midCycle();
    checkOutput("ord_rd_ack", bus.s_wb_ack, 4'b1000);
    checkOutput("ord_rd_dat", bus.s_wb_dat_s2m, 16'hCAFE);
    checkOutput("ord_wr_valid", bus.cmd_o_valid, 1);
    checkOutput("ord_wr_addr", bus.cmd_o_addr, 23'h31);
    checkOutput("ord_wr_sel", bus.cmd_o_sel, 2'b01);
    checkOutput("ord_wr_go", bus.s_wb_stall, 4'b0111);
    nextCycle();
    applyStimulus(3, 23'h31, 16'h1234, 2'b01, 1'b1, 1'b0);
    midCycle();
    checkOutput("ord_wr_ack", bus.s_wb_ack, 4'b1000);
    nextCycle();
    midCycle();
    checkOutput("ord_ack_clr", bus.s_wb_ack, 0);

    // Tag FIFO full: reads stall, an idle port's write still proceeds
    doReset();
    for (int i = 0; i < MAXR; i++) begin
      applyStimulus(0, AB'(32'h200 + i), 16'h0, 2'b11, 1'b0, 1'b1);
      midCycle();
      checkOutput("fill_stall", bus.s_wb_stall, 4'b1110);
      nextCycle();
    end
    applyStimulus(0, 23'h99, 16'h0, 2'b11, 1'b0, 1'b1);
    applyStimulus(1, 23'h55, 16'h7777, 2'b11, 1'b1, 1'b1);
    midCycle();
    checkOutput("full_wr_stall", bus.s_wb_stall, 4'b1101);
    checkOutput("full_wr_addr", bus.cmd_o_addr, 23'h55);
    checkOutput("full_wr_we", bus.cmd_o_we, 1);
    nextCycle();
    applyStimulus(1, 23'h55, 16'h7777, 2'b11, 1'b1, 1'b0);
    midCycle();
    checkOutput("full_rd_valid", bus.cmd_o_valid, 0);
    checkOutput("full_rd_stall", bus.s_wb_stall, 4'hF);
    checkOutput("full_wr_ack", bus.s_wb_ack, 4'b0010);
    nextCycle();
    bus.rsp_i_valid = 1'b1;
    bus.rsp_i_dat   = 16'h0042;
    midCycle();
    checkOutput("pop_rd_valid", bus.cmd_o_valid, 1);
    checkOutput("pop_rd_stall", bus.s_wb_stall, 4'b1110);
    checkOutput("pop_rd_addr", bus.cmd_o_addr, 23'h99);
    nextCycle();
    bus.rsp_i_valid = 1'b0;
    midCycle();
    checkOutput("pop_ack", bus.s_wb_ack, 4'b0001);
    checkOutput("pop_dat", bus.s_wb_dat_s2m, 16'h0042);
    checkOutput("refull_valid", bus.cmd_o_valid, 0);
    nextCycle();

    // Dropped response sets err; reset mid-burst clears everything
    doReset();
    bus.rsp_i_valid = 1'b1;
    bus.rsp_i_dat   = 16'hDEAD;
    nextCycle();
    bus.rsp_i_valid = 1'b0;
    midCycle();
    checkOutput("drop_ack", bus.s_wb_ack, 0);
    checkOutput("drop_err", bus.err, 1);
    checkOutput("drop_dat", bus.s_wb_dat_s2m, 0);
    nextCycle();
    midCycle();
    checkOutput("err_sticky", bus.err, 1);
    nextCycle();
    for (int p = 0; p < NP; p++)
      applyStimulus(p, AB'(32'h100 + p), 16'(32'h2000 + p), 2'b11, 1'b1, 1'b1);
    nextCycle();
    nextCycle();
    midCycle();
    checkOutput("burst_ack", bus.s_wb_ack, 4'b0010);
    nextCycle();
    sresetn = 1'b0;
    #1;
    checkOutput("mid_rst_err", bus.err, 0);
    checkOutput("mid_rst_ack", bus.s_wb_ack, 0);
    @(posedge clk);
    #1 sresetn = 1'b1;
    midCycle();
    checkOutput("post_rst_stall", bus.s_wb_stall, 4'b1110);
    checkOutput("post_rst_addr", bus.cmd_o_addr, 23'h100);
    checkOutput("post_rst_ack", bus.s_wb_ack, 0);
    nextCycle();
    clearInputs();
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_mport.md
Name: wb_sdram_mport

Overview:
- Multi-port Wishbone (pipelined) front-end for the SDRAM controller command interface.
- Round-robin arbitrates NUM_PORTS masters onto one command stream carrying address, write data and byte selects.
- Routes in-order read data back to the issuing port using a port-ID tag FIFO.
- Sits between the system interconnect and the SDRAM command FIFO/controller; adds multi-master sharing, byte-select and ordering protection per port.

Parameters:
- NUM_PORTS, 4, number of Wishbone slave ports (>=1).
- ADDR_BITS, 23, word address width (bank+row+col).
- DATA_BYTES, 2, data width in bytes.
- MAX_RD_OUTSTANDING, 8, total reads in flight; sets tag FIFO depth.
- PORT_BITS, $clog2(NUM_PORTS) min 1, derived port-ID width.

Ports:
- clk  in  1  clock.
- sresetn  in  1  asynchronous active-low reset.
- s_wb_addr  in  NUM_PORTS*ADDR_BITS  per-port address, port p at slice p.
- s_wb_dat_m2s  in  NUM_PORTS*DATA_BYTES*8  per-port write data.
- s_wb_sel  in  NUM_PORTS*DATA_BYTES  per-port byte enables.
- s_wb_we  in  NUM_PORTS  per-port write enable.
- s_wb_stb  in  NUM_PORTS  per-port strobe.
- s_wb_stall  out  NUM_PORTS  per-port stall.
- s_wb_ack  out  NUM_PORTS  per-port ack.
- s_wb_dat_s2m  out  DATA_BYTES*8  read data, shared by all ports, qualified by that port's ack.
- cmd_o_valid  out  1  command valid.
- cmd_o_ready  in  1  controller accepts the command.
- cmd_o_addr  out  ADDR_BITS  command address.
- cmd_o_we  out  1  command is a write.
- cmd_o_dat  out  DATA_BYTES*8  write data.
- cmd_o_sel  out  DATA_BYTES  byte enables; controller drives dqm = ~sel.
- rsp_i_valid  in  1  read data valid from controller, in command order.
- rsp_i_dat  in  DATA_BYTES*8  read data.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: s_wb_ack=0, s_wb_dat_s2m=0, err=0, rr_ptr=0, tag FIFO empty, all per-port read counters 0.
- Combinational outputs follow from reset state: cmd_o_valid=0, s_wb_stall=all 1s until eligibility is re-evaluated.
- Eligibility: port p is eligible when stb[p] is high and either:
  - we[p]=1 and rd_cnt[p]==0 (a write must not overtake that port's own pending reads), or
  - we[p]=0 and the tag FIFO is not full.
- Arbitration: grant goes to the first eligible port scanning from rr_ptr upward with wrap. Selection is combinational; cmd_o_* are muxed from the granted port.
- cmd_o_valid = any port eligible.
- Accept = cmd_o_valid && cmd_o_ready. On accept, rr_ptr <= grant+1 (wraps NUM_PORTS-1 -> 0). No accept means rr_ptr holds.
- Stall: s_wb_stall[p] = !(accept && grant==p). A non-granted port with stb high stays stalled, holding its request.
- Write ack: s_wb_ack[grant] asserted the cycle after a write accept, for 1 cycle.
- Read issue: on a read accept, push grant into the tag FIFO and increment rd_cnt[grant].
- Read return: on rsp_i_valid with tag FIFO non-empty:
  - pop the head tag t and decrement rd_cnt[t];
  - next cycle: s_wb_dat_s2m <= rsp_i_dat and s_wb_ack[t]=1.
- Simultaneous push and pop in the same cycle: FIFO count unchanged, no full/empty glitch. The same port may increment and decrement together; rd_cnt stays net unchanged.
- rsp_i_valid with tag FIFO empty: response dropped, err <= 1. err stays set until reset.
- Same-cycle acks: a write ack to port a and a read ack to port b!=a are both allowed. The same port cannot receive both, because the rd_cnt==0 rule forbids it.
- Full tag FIFO: all reads stall; writes from ports with rd_cnt==0 still proceed.
- NUM_PORTS=1: arbiter degenerates; rr_ptr is constant 0.
- Reset mid-operation: all in-flight state is discarded. The controller shares sresetn, so no stale responses arrive after reset.

Decomposition:
- Package wb_sdram_pkg holds the port-ID typedef and a command struct {addr, we, dat, sel}; the struct is reused by the controller.
- Sub-module rr_arbiter: request vector and advance strobe in, one-hot grant plus index out, owns rr_ptr.
- The tag FIFO is an existing axis_fifo instance (tuser = port ID, DEPTH = MAX_RD_OUTSTANDING).

Test Plan:
- Single write from port 0: addr 0x000123, dat 0xBEEF, sel 2'b11, ready=1 -> cmd_o_valid same cycle with the same fields; s_wb_ack[0] the next cycle; stall[0]=0 on the accept cycle.
- Round-robin: all 4 ports strobe writes continuously, ready=1 -> grants 0,1,2,3,0,... with no port served twice before the others; with ready=0 for 3 cycles, grant holds at 1 and rr_ptr does not advance.
- Read routing: port 2 reads addr 0x10, port 1 reads addr 0x20; responses 0xAAAA then 0x5555 -> ack[2] with 0xAAAA, then ack[1] with 0x5555, each 1 cycle after its rsp_i_valid.
- Ordering guard: port 3 issues a read then a write -> write stalls until the read response acks, then is accepted; acks arrive in issue order.
- Tag full: 8 reads outstanding with MAX_RD_OUTSTANDING=8 -> a 9th read stalls while a write on an idle port proceeds; one response frees a slot and the 9th read is accepted the same cycle the pop occurs.
- Error/reset: rsp_i_valid while idle -> no ack, err=1; assert sresetn low mid-burst -> err=0, acks=0, the next request is served from port 0 first.
